// File: rtl/line_buffer_if.sv
// line_buffer_if -- pixel stream in / 3x3 window out for the conv front end.
//   din          : signed pixel, one per clock (master drives)
//   window_flat  : 3x3 window, element idx at [(idx+1)*DATA_WIDTH-1 -: DATA_WIDTH]
//   window_valid : window fully inside the image (only with LINE_BUFFER_VALID_EN)
// Optional feature macro: LINE_BUFFER_VALID_EN
interface line_buffer_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0]   din;
  logic [9*DATA_WIDTH-1:0] window_flat;
`ifdef LINE_BUFFER_VALID_EN
  logic                    window_valid;

  modport master (output din, input window_flat, input window_valid);
  modport slave  (input din, output window_flat, output window_valid);
`else
  modport master (output din, input window_flat);
  modport slave  (input din, output window_flat);
`endif
endinterface

// File: rtl/line_buffer.sv
// line_buffer -- streaming 3x3 sliding-window generator.
//   Raster-order pixels enter one per clock; the two previous rows live in a
//   tapped shift register and a 3x3 neighbourhood is presented every cycle.
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous active-low reset (0 = in reset)
//   bus    : line_buffer_if.slave (din in, window_flat / window_valid out)
// Parameters: DATA_WIDTH bits per pixel, IMG_WIDTH pixels per row (>= 3).
// Optional feature macro: LINE_BUFFER_VALID_EN adds the registered
//   window_valid flag and the row/column position counters behind it.
module line_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int IMG_WIDTH  = 4
) (
  input  logic       clk,
  input  logic       reset,
  line_buffer_if.slave bus
);

  localparam int W     = IMG_WIDTH;
  localparam int DEPTH = 2 * W + 3;

  // sr[0] is the newest pixel; sr[W] and sr[2W] line up with the same column
  // one and two rows earlier.
  logic [DATA_WIDTH-1:0] sr [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int n = 0; n < DEPTH; n++) sr[n] <= '0;
    end else begin
      sr[0] <= bus.din;
      for (int n = 1; n < DEPTH; n++) sr[n] <= sr[n-1];
    end
  end

  // Highest element (idx8) is the newest pixel; pure pass-through of registers.
  assign bus.window_flat = {sr[0],     sr[1],     sr[2],
                            sr[W],     sr[W+1],   sr[W+2],
                            sr[2*W],   sr[2*W+1], sr[2*W+2]};

`ifdef LINE_BUFFER_VALID_EN
  localparam int CW = $clog2(W);

  // col/row give the position of the pixel being sampled on this edge;
  // row saturates at 2 because only "at least two full rows seen" matters.
  logic [CW-1:0] col;
  logic [1:0]    row;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col              <= '0;
      row              <= '0;
      bus.window_valid <= 1'b0;
    end else begin
      bus.window_valid <= (row == 2'd2) && (col >= CW'(2));
      if (col == CW'(W - 1)) begin
        col <= '0;
        if (row != 2'd2) row <= row + 2'd1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_line_buffer.sv
// tb_line_buffer -- directed self-checking bench for line_buffer
// (DATA_WIDTH=16, IMG_WIDTH=4, pixel k = k<<8).
// Build with +define+LINE_BUFFER_VALID_EN to also check window_valid.
module tb_line_buffer;
  localparam int DW = 16;
  localparam int IW = 4;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  line_buffer_if #(.DATA_WIDTH(DW)) bus ();

  line_buffer #(.DATA_WIDTH(DW), .IMG_WIDTH(IW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] elem(input int idx);
    return bus.window_flat[idx*DW +: DW];
  endfunction

  task automatic check_window(input string tag, input logic [DW-1:0] exp [9]);
    for (int i = 0; i < 9; i++)
      check($sformatf("%s idx%0d", tag, i), 32'(elem(i)), 32'(exp[i]));
  endtask

  // Drive a pixel, clock it in, sample 1 time unit after the edge.
  task automatic push(input logic [DW-1:0] v);
    bus.din = v;
    @(posedge clk);
    #1;
  endtask

  task automatic check_valid(input string tag, input logic exp);
`ifdef LINE_BUFFER_VALID_EN
    check(tag, 32'(bus.window_valid), 32'(exp));
`endif
  endtask

  function automatic logic valid_after(input int k);
    return (k == 11) || (k == 12) || (k == 15) || (k == 16);
  endfunction

  logic [DW-1:0] zeros [9];
  logic [DW-1:0] exp_first [9];
  logic [DW-1:0] exp_11 [9];
  logic [DW-1:0] exp_16 [9];
  // sr tap index -> window idx (-1 = not a tap), for IMG_WIDTH=4
  int tap_idx [11];

  initial begin
    zeros     = '{default: 16'd0};
    exp_first = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd256};
    exp_11    = '{16'd256, 16'd512, 16'd768, 16'd1280, 16'd1536, 16'd1792,
                  16'd2304, 16'd2560, 16'd2816};
    exp_16    = '{16'd1536, 16'd1792, 16'd2048, 16'd2560, 16'd2816, 16'd3072,
                  16'd3584, 16'd3840, 16'd4096};
    tap_idx   = '{8, 7, 6, -1, 5, 4, 3, -1, 2, 1, 0};

    // 1. reset held for two clocks, then first pixel
    reset   = 1'b0;
    bus.din = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    check_window("reset", zeros);
    check_valid("reset valid", 1'b0);
    @(negedge clk);
    reset = 1'b1;
    push(16'd256);
    check_window("first", exp_first);
    check_valid("valid p1", 1'b0);

    // 2./6. pixels 2..11, valid tracked per pixel
    for (int k = 2; k <= 11; k++) begin
      push(DW'(k << 8));
      check_valid($sformatf("valid p%0d", k), valid_after(k));
    end
    check_window("after11", exp_11);

    // 3. pixels 12..16
    for (int k = 12; k <= 16; k++) begin
      push(DW'(k << 8));
      check_valid($sformatf("valid p%0d", k), valid_after(k));
    end
    check_window("after16", exp_16);

    // 4. negative pixel walks every tap unchanged
    push(16'hFF00);
    check("neg idx8", 32'(elem(8)), 32'h0000_FF00);
    for (int j = 1; j <= 10; j++) begin
      push(16'd0);
      if (tap_idx[j] >= 0)
        check($sformatf("neg tap sr%0d", j), 32'(elem(tap_idx[j])), 32'h0000_FF00);
    end

    // 5. async reset mid-cycle after pixel 8, then restart
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int k = 1; k <= 8; k++) push(DW'(k << 8));
    check("pre-reset idx8", 32'(elem(8)), 32'd2048);
    #3;
    reset = 1'b0;
    #1;
    check_window("async reset", zeros);
    check_valid("async reset valid", 1'b0);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      push(DW'(k << 8));
      check_valid($sformatf("restart valid p%0d", k), valid_after(k));
    end
    check_window("restart11", exp_11);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: sim time exceeded, expected finish");
    $fatal(1, "timeout");
  end
endmodule
